// File: rtl/qspi_flash_responder_pkg.sv
// Shared types and constants for the QSPI NOR-flash read responder.
// Holds the FSM state type, the opcodes it decodes and the IO enable encodings.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA1,
        DATA4,
        ID,
        IGNORE
    } qspi_state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_QOFR = 8'h6B;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    localparam logic [3:0] OE_NONE   = 4'b0000;
    localparam logic [3:0] OE_SERIAL = 4'b0010;
    localparam logic [3:0] OE_QUAD   = 4'b1111;

    // Output enables depend only on the current state, so reset clears them at once.
    function automatic logic [3:0] state_oe(input qspi_state_t s);
        case (s)
            DATA1, ID: return OE_SERIAL;
            DATA4:     return OE_QUAD;
            default:   return OE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_responder_sync_edge.sv
// 2-FF synchronizer per bit with registered previous value for rise/fall pulses.
// Pulses are one ACLK wide and aligned with the synchronized level.
module sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= din[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign level[gi] = sync_reg;
            assign rise[gi]  = sync_reg & ~prev_reg;
            assign fall[gi]  = ~sync_reg & prev_reg;
        end
    endgenerate

endmodule

// File: rtl/qspi_flash_responder.sv
// Serial NOR read-port emulator: decodes 03h / 6Bh / 9Fh on an oversampled SPI mode-0 link
// and streams bytes from an internal array that is loaded through a backdoor write port.
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int          ADDR_SIZE = 24,
    parameter int          MEM_BYTES = 256,
    parameter int          DUMMY_CYC = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    localparam int         AW        = $clog2(MEM_BYTES)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          spi_clk,
    input  logic          spi_cs_n,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic [3:0]    io_oe,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_wdata,
    output logic          busy
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_SIZE - 1);
    localparam logic [7:0] DUMMY_DONE = 8'(DUMMY_CYC);
    localparam logic [7:0] ID_BITS    = 8'd24;

    logic       sck_s, sck_rise, sck_fall;
    logic       cs_s, cs_rise, cs_fall;
    logic [3:0] io_s, io_rise, io_fall;

    sync_edge #(.WIDTH(1)) u_sck_sync (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .din   (spi_clk),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.WIDTH(1)) u_cs_sync (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .din   (spi_cs_n),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.WIDTH(4)) u_io_sync (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .din   (io_in),
        .level (io_s),
        .rise  (io_rise),
        .fall  (io_fall)
    );

    // Only IO0 is ever an input for the supported commands.
    logic sync_unused;
    assign sync_unused = ^{sck_s, cs_rise, io_rise, io_fall, io_s[3:1]};

    qspi_state_t   state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [7:0]    cmd_reg, cmd_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [7:0]    tx_reg, tx_next;
    logic [3:0]    io_out_reg, io_out_next;

    // Read port follows addr_reg every cycle, so the next byte is ready long before
    // the falling edge that consumes it; a same-cycle backdoor write returns old data.
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] rd_data;

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_data <= mem[addr_reg];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            cmd_reg    <= '0;
            addr_reg   <= '0;
            tx_reg     <= '0;
            io_out_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cmd_reg    <= cmd_next;
            addr_reg   <= addr_next;
            tx_reg     <= tx_next;
            io_out_reg <= io_out_next;
        end
    end

    logic [4:0] id_idx;
    assign id_idx = 5'd23 - cnt_reg[4:0];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cmd_next    = cmd_reg;
        addr_next   = addr_reg;
        tx_next     = tx_reg;
        io_out_next = io_out_reg;

        if (cs_s) begin
            state_next  = IDLE;
            cnt_next    = '0;
            cmd_next    = '0;
            addr_next   = '0;
            tx_next     = '0;
            io_out_next = '0;
        end else begin
            unique case (state_reg)
                // A high->low CS event is required, so a CS held low across reset is ignored.
                IDLE: begin
                    if (cs_fall) begin
                        state_next = CMD;
                        cnt_next   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_next = {cmd_reg[6:0], io_s[0]};
                        if (cnt_reg == 8'd7) begin
                            cnt_next = '0;
                            if (cmd_next == CMD_READ || cmd_next == CMD_QOFR) begin
                                state_next = ADDR;
                            end else if (cmd_next == CMD_RDID) begin
                                state_next = ID;
                            end else begin
                                state_next = IGNORE;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_next = {addr_reg[AW-2:0], io_s[0]};
                        if (cnt_reg == ADDR_LAST) begin
                            cnt_next   = '0;
                            state_next = (cmd_reg == CMD_QOFR) ? DUMMY : DATA1;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise && cnt_reg != DUMMY_DONE) begin
                        cnt_next = cnt_reg + 8'd1;
                    end else if (sck_fall && cnt_reg == DUMMY_DONE) begin
                        io_out_next = rd_data[7:4];
                        tx_next     = {rd_data[3:0], 4'h0};
                        addr_next   = addr_reg + 1'b1;
                        cnt_next    = 8'd1;
                        state_next  = DATA4;
                    end
                end
                DATA4: begin
                    if (sck_fall) begin
                        if (cnt_reg == 8'd0) begin
                            io_out_next = rd_data[7:4];
                            tx_next     = {rd_data[3:0], 4'h0};
                            addr_next   = addr_reg + 1'b1;
                            cnt_next    = 8'd1;
                        end else begin
                            io_out_next = tx_reg[7:4];
                            cnt_next    = 8'd0;
                        end
                    end
                end
                DATA1: begin
                    if (sck_fall) begin
                        if (cnt_reg == 8'd0) begin
                            io_out_next = {2'b00, rd_data[7], 1'b0};
                            tx_next     = {rd_data[6:0], 1'b0};
                            addr_next   = addr_reg + 1'b1;
                        end else begin
                            io_out_next = {2'b00, tx_reg[7], 1'b0};
                            tx_next     = {tx_reg[6:0], 1'b0};
                        end
                        cnt_next = (cnt_reg == 8'd7) ? 8'd0 : cnt_reg + 8'd1;
                    end
                end
                ID: begin
                    if (sck_fall) begin
                        if (cnt_reg < ID_BITS) begin
                            io_out_next = {2'b00, JEDEC_ID[id_idx], 1'b0};
                            cnt_next    = cnt_reg + 8'd1;
                        end else begin
                            io_out_next = '0;
                        end
                    end
                end
                IGNORE: begin
                    io_out_next = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign io_out = io_out_reg;
    assign io_oe  = state_oe(state_reg);
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Randomized closed-loop bench: drives SPI mode 0 as a controller and checks returned data
// against a byte-array model of the flash contents and the command rules.
module tb_qspi_flash_responder;

    localparam int HALF = 4;

    logic       ACLK      = 1'b0;
    logic       ARESETn   = 1'b0;
    logic       spi_clk   = 1'b0;
    logic       spi_cs_n  = 1'b1;
    logic [3:0] io_in     = 4'h0;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic       mem_we    = 1'b0;
    logic [7:0] mem_addr  = 8'h00;
    logic [7:0] mem_wdata = 8'h00;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem_model [256];

    qspi_flash_responder dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_aclk(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        @(negedge ACLK);
        mem_we    = 1'b0;
        mem_model[a] = d;
    endtask

    // One SCK period: data set after the fall, sampled by the "controller" at the rise.
    task automatic sck_cycle(input logic [3:0] drv, output logic [3:0] smp, output logic [3:0] oe);
        io_in = drv;
        wait_aclk(HALF);
        spi_clk = 1'b1;
        smp = io_out;
        oe  = io_oe;
        wait_aclk(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits);
        logic [3:0] s, o;
        for (int i = nbits - 1; i >= 0; i--) sck_cycle({3'b000, val[i]}, s, o);
    endtask

    task automatic recv1(output logic [7:0] b, inout int bad_oe);
        logic [3:0] s, o;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'h0, s, o);
            b = {b[6:0], s[1]};
            if (o !== 4'b0010) bad_oe++;
        end
    endtask

    task automatic recv4(output logic [7:0] b, inout int bad_oe);
        logic [3:0] s, o;
        b = 8'h00;
        for (int i = 0; i < 2; i++) begin
            sck_cycle(4'h0, s, o);
            b = {b[3:0], s};
            if (o !== 4'b1111) bad_oe++;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_aclk(HALF);
    endtask

    task automatic cs_end(input string tag);
        wait_aclk(HALF);
        spi_cs_n = 1'b1;
        wait_aclk(HALF * 2);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic do_read(input logic [23:0] a, input int nbytes);
        logic [7:0] b;
        int bad = 0;
        cs_begin();
        send_bits(32'h03, 8);
        send_bits(a, 24);
        check("read_busy", busy, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            recv1(b, bad);
            check($sformatf("read_a%06h_b%0d", a, i), b, mem_model[(int'(a[7:0]) + i) % 256]);
        end
        check("read_oe", bad, 0);
        cs_end("read");
        $display("txn READ  addr=%06h bytes=%0d", a, nbytes);
    endtask

    task automatic do_qread(input logic [23:0] a, input int nbytes);
        logic [7:0] b;
        logic [3:0] s, o;
        int bad_dummy = 0;
        int bad = 0;
        cs_begin();
        send_bits(32'h6B, 8);
        send_bits(a, 24);
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'h0, s, o);
            if (o !== 4'b0000) bad_dummy++;
        end
        check("qread_dummy_oe", bad_dummy, 0);
        for (int i = 0; i < nbytes; i++) begin
            recv4(b, bad);
            check($sformatf("qread_a%06h_b%0d", a, i), b, mem_model[(int'(a[7:0]) + i) % 256]);
        end
        check("qread_oe", bad, 0);
        cs_end("qread");
        $display("txn QREAD addr=%06h bytes=%0d", a, nbytes);
    endtask

    task automatic do_rdid(input int nbytes);
        logic [7:0] b;
        logic [23:0] idv = 24'hEF4018;
        int bad = 0;
        cs_begin();
        send_bits(32'h9F, 8);
        for (int i = 0; i < nbytes; i++) begin
            recv1(b, bad);
            check($sformatf("rdid_b%0d", i), b, (i < 3) ? 8'(idv >> (16 - 8 * i)) : 8'h00);
        end
        check("rdid_oe", bad, 0);
        cs_end("rdid");
        $display("txn RDID  bytes=%0d", nbytes);
    endtask

    task automatic do_unknown(input logic [7:0] c, input int ncyc);
        logic [3:0] s, o;
        logic [3:0] oe_or = 4'h0;
        logic [3:0] out_or = 4'h0;
        cs_begin();
        send_bits(32'(c), 8);
        for (int i = 0; i < ncyc; i++) begin
            sck_cycle(4'(i), s, o);
            oe_or  |= o;
            out_or |= s;
        end
        check("unk_oe", oe_or, 4'h0);
        check("unk_out", out_or, 4'h0);
        check("unk_busy", busy, 1'b1);
        cs_end("unk");
        $display("txn UNK   cmd=%02h cycles=%0d", c, ncyc);
    endtask

    // CS released partway through a 1-bit read; responder must drop the bus within a few ACLK.
    task automatic do_abort(input logic [23:0] a, input int nbits);
        logic [3:0] s, o;
        cs_begin();
        send_bits(32'h03, 8);
        send_bits(a, 24);
        for (int i = 0; i < nbits; i++) sck_cycle(4'h0, s, o);
        spi_cs_n = 1'b1;
        wait_aclk(4);
        check("abort_oe", io_oe, 4'h0);
        check("abort_busy", busy, 1'b0);
        wait_aclk(HALF * 2);
        $display("txn ABORT addr=%06h after %0d data bits", a, nbits);
    endtask

    initial begin
        logic [3:0] s, o;
        logic [3:0] oe_or;
        logic       busy_or;
        logic [7:0] c;

        wait_aclk(5);
        check("rst_oe", io_oe, 4'h0);
        check("rst_out", io_out, 4'h0);
        check("rst_busy", busy, 1'b0);
        ARESETn = 1'b1;
        wait_aclk(5);

        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'(i));
        $display("txn FILL  array[i]=i");

        // Reset in the middle of an ID transfer, released with CS still low.
        cs_begin();
        send_bits(32'h9F, 8);
        for (int i = 0; i < 10; i++) sck_cycle(4'h0, s, o);
        ARESETn = 1'b0;
        #1;
        check("rstmid_oe", io_oe, 4'h0);
        check("rstmid_out", io_out, 4'h0);
        check("rstmid_busy", busy, 1'b0);
        wait_aclk(3);
        ARESETn = 1'b1;
        wait_aclk(4);
        oe_or   = 4'h0;
        busy_or = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sck_cycle((i < 8) ? {3'b000, c_bit(8'h9F, 7 - i)} : 4'h0, s, o);
            oe_or   |= o;
            busy_or |= busy;
        end
        check("rstwait_oe", oe_or, 4'h0);
        check("rstwait_busy", busy_or, 1'b0);
        cs_end("rstwait");
        $display("txn RESET mid-ID, command ignored until CS toggles");

        do_rdid(3);
        do_rdid(4);
        do_read(24'h000010, 4);
        do_qread(24'h0000FE, 3);
        do_unknown(8'hA5, 40);
        do_read(24'h000000, 1);

        cs_begin();
        send_bits(32'h03, 8);
        send_bits(32'h000, 12);
        spi_cs_n = 1'b1;
        wait_aclk(4);
        check("addrabort_busy", busy, 1'b0);
        check("addrabort_oe", io_oe, 4'h0);
        wait_aclk(HALF * 2);
        $display("txn ABORT after 12 address bits");
        do_read(24'h000005, 1);

        for (int i = 0; i < 8; i++) bd_write(8'($urandom), 8'($urandom));
        $display("txn FILL  random bytes");
        for (int t = 0; t < 24; t++) begin
            logic [23:0] a;
            a = 24'($urandom);
            if ($urandom_range(0, 3) == 0) bd_write(a[7:0] + 8'd1, 8'($urandom));
            case ($urandom_range(0, 4))
                0: do_read(a, $urandom_range(1, 5));
                1: do_qread(a, $urandom_range(1, 5));
                2: do_rdid($urandom_range(1, 5));
                3: begin
                    do begin
                        c = 8'($urandom);
                    end while (c == 8'h03 || c == 8'h6B || c == 8'h9F);
                    do_unknown(c, $urandom_range(8, 24));
                end
                default: do_abort(a, $urandom_range(1, 12));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic c_bit(input logic [7:0] v, input int idx);
        return v[idx];
    endfunction

endmodule
